// File: rtl/store_align.sv
// store_align: store-path formatter and single-transaction write sequencer for the MEM stage.
// Decodes sw/sh/sb, checks alignment, builds lane-replicated data and byte enables, then drives one acked write.
module store_align #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam logic [5:0] OP_SB = 6'b101000;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SW = 6'b101011;

    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Count value seen in the last permitted WRITE cycle.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [31:0] addr_n, wdata_n;
    logic [3:0]  be_n;
    logic        we_n, busy_n, done_n, err_n;
    logic [1:0]  code_n;

    logic        dec_legal;
    logic        dec_mis;
    logic [3:0]  dec_be;
    logic [31:0] dec_wdata;

    // Lane decode of the incoming request; only consumed in IDLE.
    always_comb begin
        dec_legal = 1'b1;
        dec_mis   = 1'b0;
        dec_be    = 4'b0000;
        dec_wdata = 32'h0;
        case (opcode)
            OP_SB: begin
                dec_be    = 4'b0001 << addr[1:0];
                dec_wdata = {4{din[7:0]}};
            end
            OP_SH: begin
                dec_mis   = addr[0];
                dec_be    = addr[1] ? 4'b1100 : 4'b0011;
                dec_wdata = {2{din[15:0]}};
            end
            OP_SW: begin
                dec_mis   = (addr[1:0] != 2'b00);
                dec_be    = 4'b1111;
                dec_wdata = din;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        addr_n  = mem_addr;
        wdata_n = mem_wdata;
        be_n    = mem_be;
        we_n    = mem_we;
        busy_n  = busy;
        done_n  = 1'b0;
        err_n   = 1'b0;
        code_n  = err_code;
        case (state)
            IDLE: begin
                if (req) begin
                    if (!dec_legal) begin
                        err_n  = 1'b1;
                        code_n = ERR_ILLEGAL;
                    end else if (dec_mis) begin
                        err_n  = 1'b1;
                        code_n = ERR_MISALIGN;
                    end else begin
                        addr_n  = {addr[31:2], 2'b00};
                        wdata_n = dec_wdata;
                        be_n    = dec_be;
                        we_n    = 1'b1;
                        busy_n  = 1'b1;
                        cnt_n   = 8'd0;
                        state_n = WRITE;
                    end
                end
            end
            WRITE: begin
                // Ack takes priority over an expiring timeout in the same cycle.
                if (mem_ack) begin
                    we_n    = 1'b0;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (cnt == LAST_CNT) begin
                    we_n    = 1'b0;
                    busy_n  = 1'b0;
                    err_n   = 1'b1;
                    code_n  = ERR_TIMEOUT;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_be    <= 4'b0000;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_be    <= be_n;
            mem_we    <= we_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            err_code  <= code_n;
        end
    end

endmodule

// File: doc/store_align.md
# store_align

Store-path formatter and memory write sequencer for the multicycle CPU's MEM stage; the write-side counterpart of the load data-extension logic. On a one-cycle request from the controller it decodes `sw`/`sh`/`sb`, checks address alignment, and produces the byte enables and lane-replicated write data. It then drives a single write transaction to data memory with an ack handshake and a timeout. The block reports completion or a coded error back to the controller.

## Interface
- `TIMEOUT`, default 16: cycles `mem_we` may stay high without `mem_ack` before aborting. Legal range 1..255.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 1: start pulse from the controller; sampled only in IDLE.
- `opcode` in 6: `[31:26]` of the instruction, MIPS encoding: `sw`=101011, `sh`=101001, `sb`=101000.
- `addr` in 32: effective byte address.
- `din` in 32: rt register value.
- `mem_ack` in 1: memory accepted the write; meaningful only while `mem_we`=1.
- `mem_addr` out 32: word address, `{addr[31:2],2'b00}`, registered.
- `mem_wdata` out 32: lane-replicated store data, registered.
- `mem_be` out 4: byte enables; bit i selects `mem_wdata[8i+7:8i]`.
- `mem_we` out 1: write request, held until ack or timeout.
- `busy` out 1: high while in WRITE.
- `done` out 1: one-cycle pulse after a successful write.
- `err` out 1: one-cycle pulse on a rejected or aborted store.
- `err_code` out 2: 01 misaligned, 10 illegal opcode, 11 timeout. Valid while `err`=1 and held until the next `err`.

## Operation
- States: IDLE, WRITE.
- Lane rules:
  - `sb`: `mem_be` = 0001/0010/0100/1000 for `addr[1:0]` = 0/1/2/3; `mem_wdata` = `{4{din[7:0]}}`.
  - `sh`: `addr[1:0]`=00 gives `mem_be` 0011; 10 gives 1100; `addr[0]`=1 is misaligned. `mem_wdata` = `{2{din[15:0]}}`.
  - `sw`: `addr[1:0]`=00 gives `mem_be` 1111 and `mem_wdata` = `din`; any other value is misaligned.
- IDLE with `req`=1:
  - Any other opcode: `err`=1 and `err_code`=10 next cycle; stay in IDLE; no write.
  - Legal opcode but misaligned: `err`=1 and `err_code`=01 next cycle; stay in IDLE; no write.
  - Otherwise: latch `mem_addr`, `mem_be` and `mem_wdata`; set `mem_we`=1 and `busy`=1; clear the timeout counter; enter WRITE.
- WRITE:
  - `mem_ack`=1: next cycle `mem_we`=0, `busy`=0, `done`=1; return to IDLE.
  - No ack: the counter increments. If no ack arrives in the TIMEOUT-th WRITE cycle, next cycle `mem_we`=0, `busy`=0, `err`=1, `err_code`=11; return to IDLE.
  - Ack arriving in the same cycle the timeout expires: the ack wins (`done`, no `err`).
- Ignored inputs:
  - `req` while in WRITE is ignored and not queued.
  - `mem_ack` while in IDLE is ignored.
  - `opcode`, `addr` and `din` are don't-care after the request cycle; outputs hold their latched values for the whole of WRITE.
- `done` and `err` are never high in the same cycle.
- Reset (also mid-WRITE):
  - Next cycle: state IDLE, `mem_we`=0, `busy`=0, `done`=0, `err`=0, `err_code`=00, `mem_be`=0000, `mem_addr`=0, `mem_wdata`=0, counter cleared.
  - An in-flight write is abandoned without `done` or `err`.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Request at cycle N: `mem_we` high from N+1, or `err` at N+1 for a rejected store.
- Ack sampled at cycle M (with `mem_we`=1): `done` at M+1. Minimum request-to-`done` latency is 2 cycles (ack at N+1, `done` at N+2).
- Timeout: `mem_we` high for exactly TIMEOUT cycles (N+1..N+TIMEOUT); `err` at N+TIMEOUT+1.
- A new `req` is accepted in the same cycle `done` or `err` is high, because the state is already IDLE.

## Test plan
- `sb`, `addr`=0x1003, `din`=0x123456AB, ack at N+1 -> at N+1: `mem_addr`=0x1000, `mem_be`=1000, `mem_wdata`=0xABABABAB; `done` at N+2 only.
- `sh`, `addr`=0x2002, `din`=0xFFFF8001, ack delayed 3 cycles -> `mem_be`=1100, `mem_wdata`=0x80018001, `mem_we` high 4 cycles, `busy` high during those cycles, single `done`.
- `sw`, `addr`=0x0006 -> `err`=1 with `err_code`=01 at N+1; `mem_we` never rises. Then `opcode`=100011 (`lw`) -> `err_code`=10.
- `sw` with TIMEOUT=4 and no ack -> `mem_we` high exactly 4 cycles, then `err`=1 with `err_code`=11. Repeat with ack in the 4th cycle -> `done`, no `err`.
- `rst` asserted in the 2nd WRITE cycle -> next cycle all outputs at reset values, no `done`/`err`. A new `sb` afterwards completes normally.
- Second `req` during WRITE with a different `addr` -> ignored; `mem_addr` unchanged; exactly one `done`.
